// File: rtl/tx_link_arbiter.sv
// -----------------------------------------------------------------------------
// tx_link_arbiter
//   Shares the single TX lane toward the transceiver between the DCS Reply
//   builder (DCS) and the Data Header/Data packet builder (DAT). Idle time is
//   filled with Comma words, a minimum comma gap separates packets, and a
//   packet whose source stops supplying words is aborted after a timeout.
//
// Ports
//   TX_CLK, TX_RESETN            TX word clock, async active-low reset
//   dcs_req/valid/data/kchar/last  DCS source request and word stream
//   dcs_ready                    DCS word accepted when dcs_valid & dcs_ready
//   dat_*                        same as dcs_* for the DAT source
//   tx_data_out, tx_kchar_out    registered TX word and kchar flags
//   grant                        one-hot owner, bit0 = DCS, bit1 = DAT
//   abort_pulse                  one-cycle pulse when a packet times out
//   dcs_pkt_cnt, dat_pkt_cnt     completed packet counters (wrapping)
// -----------------------------------------------------------------------------
module tx_link_arbiter #(
  parameter int g_DATA_WID  = 16,
  parameter int g_KCHAR_WID = 2,
  parameter int IDLE_GAP    = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic                   TX_CLK,
  input  logic                   TX_RESETN,
  input  logic                   dcs_req,
  input  logic                   dcs_valid,
  input  logic [g_DATA_WID-1:0]  dcs_data,
  input  logic [g_KCHAR_WID-1:0] dcs_kchar,
  input  logic                   dcs_last,
  output logic                   dcs_ready,
  input  logic                   dat_req,
  input  logic                   dat_valid,
  input  logic [g_DATA_WID-1:0]  dat_data,
  input  logic [g_KCHAR_WID-1:0] dat_kchar,
  input  logic                   dat_last,
  output logic                   dat_ready,
  output logic [g_DATA_WID-1:0]  tx_data_out,
  output logic [g_KCHAR_WID-1:0] tx_kchar_out,
  output logic [1:0]             grant,
  output logic                   abort_pulse,
  output logic [15:0]            dcs_pkt_cnt,
  output logic [15:0]            dat_pkt_cnt
);

  localparam logic [g_DATA_WID-1:0]  COMMA_DATA  = g_DATA_WID'(16'hBC3C);
  localparam logic [g_KCHAR_WID-1:0] COMMA_KCHAR = g_KCHAR_WID'(2'b11);
  localparam logic [7:0]             GAP_LAST    = 8'(IDLE_GAP - 1);
  localparam logic [15:0]            TO_LAST     = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  state_t                 state_r;
  logic [7:0]             gap_cnt_r;
  logic [15:0]            to_cnt_r;
  logic                   last_owner_r;   // 1'b1 = DAT owned the lane last

  logic                   xfer_s;
  logic                   sel_valid_s;
  logic [g_DATA_WID-1:0]  sel_data_s;
  logic [g_KCHAR_WID-1:0] sel_kchar_s;
  logic                   sel_last_s;
  logic                   accept_s;
  logic                   any_req_s;
  logic                   pick_dat_s;

  // Round-robin choice: a lone requester wins, on contention the source that
  // did not own the lane last wins.
  function automatic logic rr_pick_dat(input logic dcs_rq, input logic dat_rq,
                                       input logic last_dat);
    logic pick;
    if (dcs_rq && dat_rq) begin
      pick = ~last_dat;
    end else if (dat_rq) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

  // Ready is combinational so a word offered in the first XFER cycle is taken.
  assign dcs_ready = (state_r == ST_XFER) & grant[0];
  assign dat_ready = (state_r == ST_XFER) & grant[1];

  // Select the granted source's word and decide arbitration for this cycle.
  always_comb begin
    xfer_s = (state_r == ST_XFER);
    if (grant[1]) begin
      sel_valid_s = dat_valid;
      sel_data_s  = dat_data;
      sel_kchar_s = dat_kchar;
      sel_last_s  = dat_last;
    end else begin
      sel_valid_s = dcs_valid;
      sel_data_s  = dcs_data;
      sel_kchar_s = dcs_kchar;
      sel_last_s  = dcs_last;
    end
    accept_s   = xfer_s & sel_valid_s & (grant != 2'b00);
    any_req_s  = dcs_req | dat_req;
    pick_dat_s = rr_pick_dat(dcs_req, dat_req, last_owner_r);
  end

  // Arbiter FSM with registered TX word, grant, abort pulse and counters.
  always_ff @(posedge TX_CLK or negedge TX_RESETN) begin
    if (!TX_RESETN) begin
      state_r      <= ST_GAP;
      gap_cnt_r    <= 8'd0;
      to_cnt_r     <= 16'd0;
      last_owner_r <= 1'b1;
      grant        <= 2'b00;
      abort_pulse  <= 1'b0;
      tx_data_out  <= COMMA_DATA;
      tx_kchar_out <= COMMA_KCHAR;
      dcs_pkt_cnt  <= 16'd0;
      dat_pkt_cnt  <= 16'd0;
    end else begin
      // Comma is the default fill; only an accepted word overrides it.
      abort_pulse  <= 1'b0;
      tx_data_out  <= COMMA_DATA;
      tx_kchar_out <= COMMA_KCHAR;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant        <= pick_dat_s ? 2'b10 : 2'b01;
            last_owner_r <= pick_dat_s;
            to_cnt_r     <= 16'd0;
            state_r      <= ST_XFER;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (accept_s) begin
            tx_data_out  <= sel_data_s;
            tx_kchar_out <= sel_kchar_s;
            to_cnt_r     <= 16'd0;
            if (sel_last_s) begin
              if (grant[1]) begin
                dat_pkt_cnt <= dat_pkt_cnt + 16'd1;
              end else begin
                dcs_pkt_cnt <= dcs_pkt_cnt + 16'd1;
              end
              grant     <= 2'b00;
              gap_cnt_r <= 8'd0;
              state_r   <= ST_GAP;
            end else begin
              state_r <= ST_XFER;
            end
          end else if (to_cnt_r == TO_LAST) begin
            // Stalled for TIMEOUT consecutive cycles: drop the packet uncounted.
            abort_pulse <= 1'b1;
            grant       <= 2'b00;
            gap_cnt_r   <= 8'd0;
            state_r     <= ST_GAP;
          end else begin
            to_cnt_r <= to_cnt_r + 16'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= 8'd0;
            state_r   <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        default: begin
          grant     <= 2'b00;
          gap_cnt_r <= 8'd0;
          state_r   <= ST_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_link_arbiter.sv
module tb_tx_link_arbiter;

  localparam int IDLE_GAP = 4;
  localparam int TIMEOUT  = 8;
  localparam logic [17:0] COMMA_W = {2'b11, 16'hBC3C};

  logic        TX_CLK = 1'b0;
  logic        TX_RESETN;
  logic        dcs_req, dcs_valid, dcs_last, dcs_ready;
  logic [15:0] dcs_data;
  logic [1:0]  dcs_kchar;
  logic        dat_req, dat_valid, dat_last, dat_ready;
  logic [15:0] dat_data;
  logic [1:0]  dat_kchar;
  logic [15:0] tx_data_out;
  logic [1:0]  tx_kchar_out;
  logic [1:0]  grant;
  logic        abort_pulse;
  logic [15:0] dcs_pkt_cnt, dat_pkt_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int pkt_id   = 0;
  bit mon_en   = 1'b0;
  int comma_run = 0;
  logic [17:0] sb_q[$];
  int          run_q[$];
  int          order_q[$];

  tx_link_arbiter #(.IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT)) dut (
    .TX_CLK(TX_CLK), .TX_RESETN(TX_RESETN),
    .dcs_req(dcs_req), .dcs_valid(dcs_valid), .dcs_data(dcs_data),
    .dcs_kchar(dcs_kchar), .dcs_last(dcs_last), .dcs_ready(dcs_ready),
    .dat_req(dat_req), .dat_valid(dat_valid), .dat_data(dat_data),
    .dat_kchar(dat_kchar), .dat_last(dat_last), .dat_ready(dat_ready),
    .tx_data_out(tx_data_out), .tx_kchar_out(tx_kchar_out), .grant(grant),
    .abort_pulse(abort_pulse), .dcs_pkt_cnt(dcs_pkt_cnt), .dat_pkt_cnt(dat_pkt_cnt)
  );

  always #5 TX_CLK = ~TX_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Word i of a packet: K28.0 command word first, then distinct data words.
  function automatic logic [17:0] mkword(input bit src, input int pid, input int i);
    logic [15:0] base;
    if (i == 0) return {2'b10, 16'h1C04};
    base = src ? 16'hA000 : 16'hD000;
    return {2'b00, base + 16'(pid * 16) + 16'(i)};
  endfunction

  task automatic drive(input bit src, input logic req, input logic vld,
                       input logic [17:0] w, input logic lst);
    if (src) begin
      dat_req = req; dat_valid = vld; dat_kchar = w[17:16]; dat_data = w[15:0]; dat_last = lst;
    end else begin
      dcs_req = req; dcs_valid = vld; dcs_kchar = w[17:16]; dcs_data = w[15:0]; dcs_last = lst;
    end
  endtask

  // Offers n words; a stall of stall_len cycles precedes word stall_at.
  task automatic send_pkt(input bit src, input int n, input int stall_at,
                          input int stall_len, input bit with_last, output int wait_cyc);
    int i, stalls, budget, pid;
    bit started;
    logic rdy;
    logic [17:0] w;
    i = 0; stalls = 0; budget = 0; started = 1'b0; wait_cyc = 0;
    pid = pkt_id; pkt_id++;
    while (i < n && budget < 300) begin
      w = mkword(src, pid, i);
      if (i == stall_at && stalls < stall_len) begin
        drive(src, 1'b1, 1'b0, w, 1'b0);
        stalls++;
      end else begin
        drive(src, 1'b1, 1'b1, w, with_last && (i == n - 1));
        rdy = src ? dat_ready : dcs_ready;
        if (rdy) begin
          if (!started) order_q.push_back(int'(src));
          started = 1'b1;
          chk("grant_owner", grant, src ? 2'b10 : 2'b01);
          sb_q.push_back(w);
          i++;
        end else if (!started) begin
          wait_cyc++;
        end
      end
      @(posedge TX_CLK); #2;
      budget++;
    end
    chk("send_complete", i, n);
    drive(src, 1'b0, 1'b0, 18'd0, 1'b0);
  endtask

  // Output monitor: every non-comma word must be the next scoreboard entry.
  always @(posedge TX_CLK) begin
    #1;
    if (mon_en) begin
      chk("grant_not_11", (grant == 2'b11), 1'b0);
      if ({tx_kchar_out, tx_data_out} === COMMA_W) begin
        comma_run++;
      end else begin
        run_q.push_back(comma_run);
        comma_run = 0;
        chk("sb_has_entry", (sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) chk("tx_word", {tx_kchar_out, tx_data_out}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int budget;
    TX_RESETN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 18'd0, 1'b0);
    repeat (3) @(posedge TX_CLK);
    #1;
    chk("rst_data", tx_data_out, 16'hBC3C);
    chk("rst_kchar", tx_kchar_out, 2'b11);
    chk("rst_grant", grant, 2'b00);
    chk("rst_abort", abort_pulse, 1'b0);
    #1;
    TX_RESETN = 1'b1;
    mon_en = 1'b1;

    // No requests: comma stream, no grant, counters at zero.
    for (int k = 0; k < 8; k++) begin
      @(posedge TX_CLK); #1;
      chk("idle_word", {tx_kchar_out, tx_data_out}, COMMA_W);
      chk("idle_grant", grant, 2'b00);
      chk("idle_cnts", {dcs_pkt_cnt, dat_pkt_cnt}, 32'd0);
      #1;
    end

    // Contention, twice: DCS first (last_owner resets to DAT), then alternate.
    run_q.delete(); order_q.delete();
    for (int r = 0; r < 2; r++) begin
      fork
        begin int w0; send_pkt(1'b0, 4, -1, 0, 1'b1, w0); end
        begin int w1; send_pkt(1'b1, 4, -1, 0, 1'b1, w1); end
      join
    end
    chk("order_size", order_q.size(), 4);
    for (int k = 0; k < 4 && k < order_q.size(); k++) chk("order_alt", order_q[k], k % 2);
    // Between packets: IDLE_GAP commas from GAP plus one arbitration cycle.
    chk("runs_size", run_q.size(), 16);
    if (run_q.size() == 16) begin
      chk("gap_dcs_dat", run_q[4], IDLE_GAP + 1);
      chk("gap_dat_dcs", run_q[8], IDLE_GAP + 1);
      chk("gap_dcs_dat2", run_q[12], IDLE_GAP + 1);
    end
    chk("cnt_after_rr", {dcs_pkt_cnt, dat_pkt_cnt}, {16'd2, 16'd2});

    // DCS-only 5-word packet from IDLE: grant one cycle after request.
    repeat (10) @(posedge TX_CLK);
    #2;
    send_pkt(1'b0, 5, -1, 0, 1'b1, wc);
    chk("dcs_grant_lat", wc, 1);
    for (int k = 0; k < IDLE_GAP; k++) begin
      @(posedge TX_CLK); #1;
      chk("post_pkt_comma", {tx_kchar_out, tx_data_out}, COMMA_W);
      chk("post_pkt_grant", grant, 2'b00);
      #1;
    end
    chk("dcs_cnt_3", dcs_pkt_cnt, 16'd3);

    // DAT stall of 3 cycles before word 3: three commas inside the packet.
    repeat (10) @(posedge TX_CLK);
    #2;
    run_q.delete();
    send_pkt(1'b1, 6, 3, 3, 1'b1, wc);
    @(posedge TX_CLK); #2;
    chk("stall_runs", run_q.size(), 6);
    if (run_q.size() == 6) begin
      chk("stall_run1", run_q[1], 0);
      chk("stall_run3", run_q[3], 3);
      chk("stall_run5", run_q[5], 0);
    end
    chk("dat_cnt_3", dat_pkt_cnt, 16'd3);

    // Timeout: DAT sends 2 words then goes silent; DCS waits and is served.
    repeat (10) @(posedge TX_CLK);
    #2;
    fork
      begin
        int wa;
        send_pkt(1'b1, 2, -1, 0, 1'b0, wa);
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
          @(posedge TX_CLK); #1;
          chk("abort_pulse", abort_pulse, (k == TIMEOUT));
          if (k == TIMEOUT) chk("abort_grant", grant, 2'b00);
          #1;
        end
        chk("abort_no_cnt", dat_pkt_cnt, 16'd3);
      end
      begin
        int wb;
        repeat (3) @(posedge TX_CLK);
        #2;
        send_pkt(1'b0, 3, -1, 0, 1'b1, wb);
      end
    join
    chk("dcs_after_abort", dcs_pkt_cnt, 16'd4);

    // Counter wrap from a preloaded FFFF.
    repeat (10) @(posedge TX_CLK);
    force dut.dcs_pkt_cnt = 16'hFFFF;
    @(posedge TX_CLK); #2;
    release dut.dcs_pkt_cnt;
    @(posedge TX_CLK); #1;
    chk("preload", dcs_pkt_cnt, 16'hFFFF);
    #1;
    send_pkt(1'b0, 2, -1, 0, 1'b1, wc);
    chk("cnt_wrap", dcs_pkt_cnt, 16'h0000);
    repeat (10) @(posedge TX_CLK);
    #2;
    chk("sb_drained", sb_q.size(), 0);

    // Reset in the middle of a DCS packet.
    mon_en = 1'b0;
    drive(1'b0, 1'b1, 1'b1, {2'b00, 16'h1234}, 1'b0);
    budget = 0;
    while (!dcs_ready && budget < 20) begin
      @(posedge TX_CLK); #2;
      budget++;
    end
    chk("rst_xfer_ready", dcs_ready, 1'b1);
    @(posedge TX_CLK); #1;
    chk("rst_xfer_word", tx_data_out, 16'h1234);
    chk("rst_xfer_grant", grant, 2'b01);
    #1;
    TX_RESETN = 1'b0;
    #1;
    chk("rst_mid_data", tx_data_out, 16'hBC3C);
    chk("rst_mid_kchar", tx_kchar_out, 2'b11);
    chk("rst_mid_grant", grant, 2'b00);
    chk("rst_mid_abort", abort_pulse, 1'b0);
    chk("rst_mid_cnt", dcs_pkt_cnt, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    @(posedge TX_CLK); #2;
    TX_RESETN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge TX_CLK); #1;
      chk("post_rst_word", {tx_kchar_out, tx_data_out}, COMMA_W);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
